sprite_motion_ctrl: RTL and testbench

//   Per-frame scheduler for the sprite renderer. Once per video frame, during vertical blanking,

---
 rtl/sprite_motion_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite scheduler: during vertical blanking it steps the sprite's
// bouncing top-left position and the animation bitmap select. Config writes
// land in shadow/pending registers and only reach the outputs at COMMIT, so
// the renderer never sees a change in the middle of a frame.
module sprite_motion_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_W    = 272,
  parameter int SPRITE_H    = 176,
  parameter int INIT_X      = 128,
  parameter int INIT_Y      = 128,
  parameter int ANIM_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_addr,
  input  logic [9:0] cfg_data,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       anim_frame,
  output logic       overrun
);

  localparam logic [10:0] XMAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] YMAX  = 11'(SCREEN_H - SPRITE_H);
  localparam int          CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC_X,
    S_CALC_Y,
    S_COMMIT
  } state_e;

  state_e state_q, state_d;

  logic             en_q, en_d;
  logic [3:0]       dx_q, dx_d;
  logic [3:0]       dy_q, dy_d;
  logic [9:0]       px_q, px_d;
  logic [9:0]       py_q, py_d;
  logic             px_pend_q, px_pend_d;
  logic             py_pend_q, py_pend_d;
  logic [9:0]       nx_q, nx_d;
  logic [9:0]       ny_q, ny_d;
  logic             dir_x_neg_q, dir_x_neg_d;
  logic             dir_y_neg_q, dir_y_neg_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
  logic             anim_q, anim_d;
  logic             overrun_q, overrun_d;

  logic             cfg_accept;
  logic [10:0]      step_x;
  logic [10:0]      step_y;

  // One bounce step on one axis. Result is {flip, new_pos}. The sum is taken
  // at 11 bits so an overshoot past the limit is seen instead of wrapping.
  function automatic logic [10:0] step_axis(input logic [9:0]  pos,
                                            input logic [3:0]  step,
                                            input logic        neg,
                                            input logic [10:0] lim);
    logic [10:0] sum;
    logic [9:0]  p;
    logic        flip;
    sum  = {1'b0, pos} + {7'b0, step};
    p    = pos;
    flip = 1'b0;
    if (step != 4'd0) begin
      if (!neg) begin
        if (sum >= lim) begin
          p    = lim[9:0];
          flip = 1'b1;
        end else begin
          p = sum[9:0];
        end
      end else begin
        if ({1'b0, pos} <= {7'b0, step}) begin
          p    = 10'd0;
          flip = 1'b1;
        end else begin
          p = pos - {6'b0, step};
        end
      end
    end
    return {flip, p};
  endfunction

  // Keep a host-written position inside the visible area.
  function automatic logic [9:0] clamp_pos(input logic [9:0]  v,
                                           input logic [10:0] lim);
    return ({1'b0, v} > lim) ? lim[9:0] : v;
  endfunction

  assign cfg_ready  = (state_q == S_IDLE);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign step_x     = step_axis(x_q, dx_q, dir_x_neg_q, XMAX);
  assign step_y     = step_axis(y_q, dy_q, dir_y_neg_q, YMAX);

  assign sprite_x   = x_q;
  assign sprite_y   = y_q;
  assign anim_frame = anim_q;
  assign overrun    = overrun_q;

  // Frame sequencer: one pass through the three calculation steps per frame_start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = S_CALC_X;
      S_CALC_X: state_d = S_CALC_Y;
      S_CALC_Y: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Shadow writes, per-axis position stepping, commit and animation.
  always_comb begin
    en_d        = en_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    px_d        = px_q;
    py_d        = py_q;
    px_pend_d   = px_pend_q;
    py_pend_d   = py_pend_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    dir_x_neg_d = dir_x_neg_q;
    dir_y_neg_d = dir_y_neg_q;
    x_d         = x_q;
    y_d         = y_q;
    anim_cnt_d  = anim_cnt_q;
    anim_d      = anim_q;
    // A frame_start that lands mid-calculation is dropped but remembered.
    overrun_d   = overrun_q | (frame_start && (state_q != S_IDLE));

    if (cfg_accept) begin
      case (cfg_addr)
        2'd0: en_d = cfg_data[0];
        2'd1: begin
          px_d      = clamp_pos(cfg_data, XMAX);
          px_pend_d = 1'b1;
        end
        2'd2: begin
          py_d      = clamp_pos(cfg_data, YMAX);
          py_pend_d = 1'b1;
        end
        2'd3: begin
          dx_d = cfg_data[3:0];
          dy_d = cfg_data[7:4];
        end
      endcase
    end

    case (state_q)
      S_CALC_X: begin
        // A pending host value wins and leaves the bounce direction alone.
        if (px_pend_q) begin
          nx_d = px_q;
        end else if (en_q) begin
          nx_d        = step_x[9:0];
          dir_x_neg_d = dir_x_neg_q ^ step_x[10];
        end else begin
          nx_d = x_q;
        end
      end
      S_CALC_Y: begin
        if (py_pend_q) begin
          ny_d = py_q;
        end else if (en_q) begin
          ny_d        = step_y[9:0];
          dir_y_neg_d = dir_y_neg_q ^ step_y[10];
        end else begin
          ny_d = y_q;
        end
      end
      S_COMMIT: begin
        x_d       = nx_q;
        y_d       = ny_q;
        px_pend_d = 1'b0;
        py_pend_d = 1'b0;
        if (en_q) begin
          if (anim_cnt_q == CNT_LAST) begin
            anim_cnt_d = '0;
            anim_d     = ~anim_q;
          end else begin
            anim_cnt_d = anim_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and register update; reset wins in every state and aborts a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b1;
      dx_q        <= 4'd2;
      dy_q        <= 4'd1;
      px_q        <= '0;
      py_q        <= '0;
      px_pend_q   <= 1'b0;
      py_pend_q   <= 1'b0;
      nx_q        <= 10'(INIT_X);
      ny_q        <= 10'(INIT_Y);
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      x_q         <= 10'(INIT_X);
      y_q         <= 10'(INIT_Y);
      anim_cnt_q  <= '0;
      anim_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      px_q        <= px_d;
      py_q        <= py_d;
      px_pend_q   <= px_pend_d;
      py_pend_q   <= py_pend_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      dir_x_neg_q <= dir_x_neg_d;
      dir_y_neg_q <= dir_y_neg_d;
      x_q         <= x_d;
      y_q         <= y_d;
      anim_cnt_q  <= anim_cnt_d;
      anim_q      <= anim_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: a table of {config write, frame
// count, expected position/animation} records plus hand-written sequences
// for latency, overrun, reset-in-flight and held config requests.
module tb_sprite_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [9:0] cfg_data;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       anim_frame;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [9:0] data;
    int         frames;
    int         ex;
    int         ey;
    int         ea;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  sprite_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .anim_frame (anim_frame),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [9:0] d);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL cfg_write timeout: ready stayed 0, expected 1");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic run_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    // {wr, addr, data, frames, exp_x, exp_y, exp_anim}
    vecs[0]  = '{1'b1, 2'd1, 10'd366,  1, 366, 130, 0};
    vecs[1]  = '{1'b0, 2'd0, 10'd0,    1, 368, 131, 0};
    vecs[2]  = '{1'b0, 2'd0, 10'd0,    1, 366, 132, 0};
    vecs[3]  = '{1'b1, 2'd1, 10'd1,    1,   1, 133, 0};
    vecs[4]  = '{1'b0, 2'd0, 10'd0,    1,   0, 134, 0};
    vecs[5]  = '{1'b0, 2'd0, 10'd0,    1,   2, 135, 0};
    vecs[6]  = '{1'b1, 2'd1, 10'd1000, 1, 368, 136, 0};
    vecs[7]  = '{1'b0, 2'd0, 10'd0,    1, 368, 137, 0};
    vecs[8]  = '{1'b1, 2'd2, 10'd1000, 1, 366, 304, 0};
    vecs[9]  = '{1'b0, 2'd0, 10'd0,    1, 364, 304, 0};
    vecs[10] = '{1'b0, 2'd0, 10'd0,    1, 362, 303, 0};
    vecs[11] = '{1'b1, 2'd3, 10'h030,  1, 362, 300, 0};
    vecs[12] = '{1'b1, 2'd3, 10'h025,  1, 357, 298, 0};
    vecs[13] = '{1'b0, 2'd0, 10'd0,    1, 352, 296, 0};
    vecs[14] = '{1'b0, 2'd0, 10'd0,    1, 347, 294, 1};
    vecs[15] = '{1'b1, 2'd0, 10'd0,    5, 347, 294, 1};
    vecs[16] = '{1'b1, 2'd1, 10'd10,   1,  10, 294, 1};
    vecs[17] = '{1'b1, 2'd0, 10'd1,    1,   5, 292, 1};
    vecs[18] = '{1'b0, 2'd0, 10'd0,   14,  65, 264, 1};
    vecs[19] = '{1'b0, 2'd0, 10'd0,    1,  70, 262, 0};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    cfg_addr    = 2'd0;
    cfg_data    = 10'd0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset x", int'(sprite_x), 128);
    check("reset y", int'(sprite_y), 128);
    check("reset anim", int'(anim_frame), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset ready", int'(cfg_ready), 1);

    // First frame: three-cycle latency, ready low for exactly those cycles
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("lat ready c1", int'(cfg_ready), 0);
    check("lat x c1", int'(sprite_x), 128);
    @(negedge clk);
    check("lat ready c2", int'(cfg_ready), 0);
    @(negedge clk);
    check("lat ready c3", int'(cfg_ready), 0);
    check("lat x c3", int'(sprite_x), 128);
    @(negedge clk);
    check("lat ready c4", int'(cfg_ready), 1);
    check("lat x", int'(sprite_x), 130);
    check("lat y", int'(sprite_y), 129);
    check("lat anim", int'(anim_frame), 0);

    // Table: bounce, clamp, speed, animation period and enable
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr) cfg_write(vecs[i].addr, vecs[i].data);
      for (int f = 0; f < vecs[i].frames; f++) run_frame();
      check($sformatf("vec%0d x", i), int'(sprite_x), vecs[i].ex);
      check($sformatf("vec%0d y", i), int'(sprite_y), vecs[i].ey);
      check($sformatf("vec%0d anim", i), int'(anim_frame), vecs[i].ea);
    end

    // Overrun: second frame_start during calculation is dropped
    do_reset();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("ovr x", int'(sprite_x), 130);
    check("ovr y", int'(sprite_y), 129);
    check("ovr flag", int'(overrun), 1);
    check("ovr ready", int'(cfg_ready), 1);
    repeat (4) @(negedge clk);
    check("ovr single update x", int'(sprite_x), 130);
    check("ovr sticky", int'(overrun), 1);

    // Reset asserted while in CALC_Y aborts the frame
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid x", int'(sprite_x), 128);
    check("rst mid y", int'(sprite_y), 128);
    check("rst mid anim", int'(anim_frame), 0);
    check("rst mid overrun", int'(overrun), 0);
    check("rst mid ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst abort x", int'(sprite_x), 128);
    check("rst abort y", int'(sprite_y), 128);

    // cfg_valid held across a busy window is accepted on the first IDLE cycle
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cfg_valid   = 1'b1;
    cfg_addr    = 2'd1;
    cfg_data    = 10'd200;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held wait cycles", n, 3);
    check("held x before accept", int'(sprite_x), 130);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("held x after accept", int'(sprite_x), 130);
    run_frame();
    check("held x commit", int'(sprite_x), 200);
    check("held y commit", int'(sprite_y), 130);

    // Write accepted on the same edge as frame_start lands in that frame
    @(negedge clk);
    frame_start = 1'b1;
    cfg_valid   = 1'b1;
    cfg_addr    = 2'd1;
    cfg_data    = 10'd50;
    @(negedge clk);
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    repeat (3) @(negedge clk);
    check("same edge x", int'(sprite_x), 50);
    check("same edge y", int'(sprite_y), 131);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
